vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_counter.sv | 51 +++++
 rtl/vga_timing_gen.sv | 85 ++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and counter types.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int FRAME_W = 8;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [FRAME_W-1:0] frame_cnt_t;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/sync_counter.sv
// One wrapping timing axis: counter plus registered active-low sync decode.
module sync_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_last,
    output logic             sync_n,
    output logic             active_nxt
);

    localparam int   TOTAL   = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam cnt_t LAST    = CNT_W'(TOTAL - 1);
    localparam cnt_t SYNC_LO = CNT_W'(ACTIVE + FRONT);
    localparam cnt_t SYNC_HI = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam cnt_t ACT_END = CNT_W'(ACTIVE);

    cnt_t cnt_q, cnt_d;
    logic sync_n_q, sync_n_d;

    assign at_last = (cnt_q == LAST);

    // Decode from the next count so the sync flop lines up with the count flop.
    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        sync_n_d   = !((cnt_d >= SYNC_LO) && (cnt_d <= SYNC_HI));
        active_nxt = (cnt_d < ACT_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= LAST;
            sync_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign cnt    = cnt_q;
    assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, registered syncs, blanking and frame markers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    output logic [CNT_W-1:0]   hpos,
    output logic [CNT_W-1:0]   vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    logic h_last, v_last, h_act_nxt, v_act_nxt;

    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       display_on_q, display_on_d;
    frame_cnt_t frame_cnt_q, frame_cnt_d;

    sync_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk        (clk),
        .rst        (reset),
        .en         (tick),
        .cnt        (hpos),
        .at_last    (h_last),
        .sync_n     (hsync),
        .active_nxt (h_act_nxt)
    );

    sync_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk        (clk),
        .rst        (reset),
        .en         (line_start_d),
        .cnt        (vpos),
        .at_last    (v_last),
        .sync_n     (vsync),
        .active_nxt (v_act_nxt)
    );

    // Reset parks both counters on their last value so the first tick lands on (0,0).
    always_comb begin
        line_start_d  = tick && h_last;
        frame_start_d = line_start_d && v_last;
        frame_cnt_d   = frame_cnt_q + FRAME_W'(frame_start_d);
        display_on_d  = h_act_nxt && v_act_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            display_on_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            display_on_q  <= display_on_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign display_on  = display_on_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 16x10 raster so whole-frame runs stay short.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk, reset, tick;
    logic [9:0] hpos, vpos;
    logic       hsync, vsync, display_on, line_start, frame_start;
    logic [7:0] frame_cnt;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .hpos        (hpos),
        .vpos        (vpos),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic t;
        int   h, v;
        logic hs, vs, de, ls, fs;
        int   fc;
    } vec_t;

    vec_t vecs[$];
    int errors = 0, checks = 0;
    int m_h, m_v, m_fc;
    int hs_low, vs_low, de_cnt, ls_n, fs_n, cyc, last_fs;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic add(input logic t, input int h, input int v, input logic hs, input logic vs,
                       input logic de, input logic ls, input logic fs, input int fc);
        vec_t r;
        r.t = t; r.h = h; r.v = v; r.hs = hs; r.vs = vs;
        r.de = de; r.ls = ls; r.fs = fs; r.fc = fc;
        vecs.push_back(r);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hpos"}, hpos, HT - 1);
        check({tag, "_vpos"}, vpos, VT - 1);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_de"}, display_on, 0);
        check({tag, "_ls"}, line_start, 0);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_fc"}, frame_cnt, 0);
    endtask

    task automatic model_init();
        m_h = HT - 1; m_v = VT - 1; m_fc = 0;
        hs_low = 0; vs_low = 0; de_cnt = 0; ls_n = 0; fs_n = 0; cyc = 0; last_fs = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_init();
    endtask

    // Independent raster model stepped once per clock; tick on every period-th clock.
    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            logic t, e_ls, e_fs, e_hs, e_vs, e_de;
            logic [32:0] g, w;
            t = ((i % period) == 0);
            tick = t;
            @(negedge clk);
            e_ls = 1'b0; e_fs = 1'b0;
            if (t) begin
                e_ls = (m_h == HT - 1);
                e_fs = e_ls && (m_v == VT - 1);
                m_h  = e_ls ? 0 : m_h + 1;
                if (e_ls) m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                if (e_fs) m_fc = (m_fc + 1) % 256;
            end
            e_hs = !((m_h >= HA + HF) && (m_h <= HA + HF + HS - 1));
            e_vs = !((m_v >= VA + VF) && (m_v <= VA + VF + VS - 1));
            e_de = (m_h < HA) && (m_v < VA);
            w = {10'(m_h), 10'(m_v), e_hs, e_vs, e_de, e_ls, e_fs, 8'(m_fc)};
            g = {hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt};
            check("model", g, w);
            cyc++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (display_on) de_cnt++;
            if (line_start) ls_n++;
            if (frame_start) begin
                fs_n++;
                if (last_fs >= 0) check("frame_period", cyc - last_fs, HT * VT);
                last_fs = cyc;
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; tick = 1'b1;
        #2;
        check_reset_vals("rst0");
        @(negedge clk);
        check_reset_vals("rst_edge");

        // tick, h, v, hs, vs, de, ls, fs, fc
        add(1,  0, 0, 1, 1, 1, 1, 1, 1);
        add(0,  0, 0, 1, 1, 1, 0, 0, 1);
        add(0,  0, 0, 1, 1, 1, 0, 0, 1);
        add(1,  1, 0, 1, 1, 1, 0, 0, 1);
        add(1,  2, 0, 1, 1, 1, 0, 0, 1);
        add(1,  3, 0, 1, 1, 1, 0, 0, 1);
        add(1,  4, 0, 1, 1, 1, 0, 0, 1);
        add(1,  5, 0, 1, 1, 1, 0, 0, 1);
        add(1,  6, 0, 1, 1, 1, 0, 0, 1);
        add(1,  7, 0, 1, 1, 1, 0, 0, 1);
        add(1,  8, 0, 1, 1, 0, 0, 0, 1);
        add(1,  9, 0, 1, 1, 0, 0, 0, 1);
        add(1, 10, 0, 0, 1, 0, 0, 0, 1);
        add(0, 10, 0, 0, 1, 0, 0, 0, 1);
        add(1, 11, 0, 0, 1, 0, 0, 0, 1);
        add(1, 12, 0, 0, 1, 0, 0, 0, 1);
        add(1, 13, 0, 1, 1, 0, 0, 0, 1);
        add(1, 14, 0, 1, 1, 0, 0, 0, 1);
        add(1, 15, 0, 1, 1, 0, 0, 0, 1);
        add(1,  0, 1, 1, 1, 1, 1, 0, 1);
        add(0,  0, 1, 1, 1, 1, 0, 0, 1);

        tick = 1'b0;
        reset = 1'b0;
        foreach (vecs[i]) begin
            tick = vecs[i].t;
            @(negedge clk);
            check($sformatf("v%0d_hpos", i), hpos, vecs[i].h);
            check($sformatf("v%0d_vpos", i), vpos, vecs[i].v);
            check($sformatf("v%0d_hsync", i), hsync, vecs[i].hs);
            check($sformatf("v%0d_vsync", i), vsync, vecs[i].vs);
            check($sformatf("v%0d_de", i), display_on, vecs[i].de);
            check($sformatf("v%0d_ls", i), line_start, vecs[i].ls);
            check($sformatf("v%0d_fs", i), frame_start, vecs[i].fs);
            check($sformatf("v%0d_fc", i), frame_cnt, vecs[i].fc);
        end

        // Sparse tick 1,0,0,0: 32 ticks from reset -> two line entries, ends at (15,1).
        do_reset();
        run(4 * HT * 2, 4);
        check("sparse_ls_count", ls_n, 2);
        check("sparse_hpos", hpos, 15);
        check("sparse_vpos", vpos, 1);

        // 256 back-to-back frames: frame_cnt wraps to 0 on the 256th frame start.
        do_reset();
        run(256 * HT * VT, 1);
        check("wrap_fs_count", fs_n, 256);
        check("wrap_frame_cnt", frame_cnt, 0);
        check("wrap_hs_low", hs_low, 256 * VT * HS);
        check("wrap_vs_low", vs_low, 256 * VS * HT);
        check("wrap_de_count", de_cnt, 256 * VA * HA);
        check("wrap_ls_count", ls_n, 256 * VT);

        // Mid-frame async reset lands before the next clock edge.
        do_reset();
        run(60, 1);
        check("pre_async_hpos", hpos, 11);
        check("pre_async_vpos", vpos, 3);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("rel_hpos", hpos, 0);
        check("rel_vpos", vpos, 0);
        check("rel_de", display_on, 1);
        check("rel_ls", line_start, 1);
        check("rel_fs", frame_start, 1);
        check("rel_fc", frame_cnt, 1);
        @(negedge clk);
        check("rel_ls_drop", line_start, 0);
        check("rel_hold_hpos", hpos, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
